// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the instruction-fetch side (I, read-only)
// and the data side (D, load/store). One transaction is outstanding at a time.
//
// Arbitration: D beats I, except when I has been passed over STARVE_LIMIT times in a row
// while waiting; then I is forced to win.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   i_req_*                  I-side read request (valid/addr) and same-cycle ready
//   i_resp_*                 I-side one-cycle response pulse with read data
//   d_req_*                  D-side request (valid/we/addr/wdata) and same-cycle ready
//   d_resp_*                 D-side one-cycle response pulse (load data, or 0 for stores)
//   mem_req_*                registered request to memory, held stable until mem_req_ready
//   mem_resp_*               memory response/ack (for both reads and writes)
module mem_arbiter #(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // I side
  input  logic              i_req_valid,
  input  logic [AWIDTH-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [DWIDTH-1:0] i_resp_data,
  // D side
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [AWIDTH-1:0] d_req_addr,
  input  logic [DWIDTH-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DWIDTH-1:0] d_resp_data,
  // Memory side
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [3:0]          starve_q;
  logic                mem_req_valid_q;
  logic                mem_req_we_q;
  logic [AWIDTH-1:0]   mem_req_addr_q;
  logic [DWIDTH-1:0]   mem_req_wdata_q;
  logic                i_resp_valid_q;
  logic [DWIDTH-1:0]   i_resp_data_q;
  logic                d_resp_valid_q;
  logic [DWIDTH-1:0]   d_resp_data_q;

  logic              in_idle;
  logic              d_wins;
  logic              grant_i;
  logic              grant_d;
  logic              resp_done;
  logic [DWIDTH-1:0] resp_payload;

  always_comb begin
    // Grants are suppressed while reset is held so every output reads 0 during reset.
    in_idle = (state_q == StIdle) && !rst;
    d_wins  = d_req_valid && (!i_req_valid || (starve_q != StarveMax));
    grant_d = in_idle && d_wins;
    grant_i = in_idle && i_req_valid && !d_wins;
    // A response accepted together with the request in ISSUE completes the transaction.
    resp_done = ((state_q == StWaitResp) && mem_resp_valid) ||
                ((state_q == StIssue) && mem_req_ready && mem_resp_valid);
    // Stores return an ack with zero data; only loads forward memory data.
    resp_payload = mem_req_we_q ? '0 : mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      owner_q         <= OwnNone;
      starve_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      i_resp_valid_q  <= 1'b0;
      i_resp_data_q   <= '0;
      d_resp_valid_q  <= 1'b0;
      d_resp_data_q   <= '0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;

      if (resp_done) begin
        if (owner_q == OwnI) begin
          i_resp_valid_q <= 1'b1;
          i_resp_data_q  <= resp_payload;
        end else if (owner_q == OwnD) begin
          d_resp_valid_q <= 1'b1;
          d_resp_data_q  <= resp_payload;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (grant_d || grant_i) begin
            mem_req_valid_q <= 1'b1;
            state_q         <= StIssue;
          end
          if (grant_d) begin
            owner_q         <= OwnD;
            mem_req_we_q    <= d_req_we;
            mem_req_addr_q  <= d_req_addr;
            mem_req_wdata_q <= d_req_wdata;
            // Count only grants that made a waiting I lose; saturate at the limit.
            if (i_req_valid && (starve_q < StarveMax)) begin
              starve_q <= 4'(starve_q + 4'd1);
            end
          end else if (grant_i) begin
            owner_q         <= OwnI;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= i_req_addr;
            mem_req_wdata_q <= '0;
            starve_q        <= '0;
          end
        end
        StIssue: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            if (mem_resp_valid) begin
              state_q <= StIdle;
              owner_q <= OwnNone;
            end else begin
              state_q <= StWaitResp;
            end
          end
        end
        StWaitResp: begin
          if (mem_resp_valid) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
          end
        end
        default: begin
          state_q <= StIdle;
          owner_q <= OwnNone;
        end
      endcase
    end
  end

  assign i_req_ready   = grant_i;
  assign d_req_ready   = grant_d;
  assign i_resp_valid  = i_resp_valid_q;
  assign i_resp_data   = i_resp_data_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_data   = d_resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tests push expected memory requests and responses,
// a memory responder and a response monitor pop and compare them independently.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  // Responder-driven and hand-driven memory inputs are kept apart and merged.
  logic        auto_rdy, auto_rv, man_rdy, man_rv;
  logic [31:0] auto_rd, man_rd;
  assign mem_req_ready  = auto_rdy | man_rdy;
  assign mem_resp_valid = auto_rv | man_rv;
  assign mem_resp_data  = auto_rd | man_rd;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_req_ready   (i_req_ready),
    .i_resp_valid  (i_resp_valid),
    .i_resp_data   (i_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_ready   (d_req_ready),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_mem_q[$];   // {we, addr, wdata}
  logic [32:0] exp_resp_q[$];  // {is_d, data}

  bit auto_mem  = 1'b1;
  int rdy_delay = 0;
  int resp_lat  = 2;
  bit same_cyc  = 1'b0;

  int i_grant_cyc, d_grant_cyc, resp_cyc, i_resp_cyc, d_resp_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_mem_q.push_back({we, a, wd});
  endtask

  task automatic exp_resp(input logic is_d, input logic [31:0] data);
    exp_resp_q.push_back({is_d, data});
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
  endfunction

  // Memory responder: checks each request against the scoreboard, then answers.
  initial begin : responder
    logic [64:0] e;
    auto_rdy = 1'b0;
    auto_rv  = 1'b0;
    auto_rd  = '0;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req_valid) begin
        if (exp_mem_q.size() == 0) begin
          fail_now("unexpected_mem_req", $sformatf("got addr %h want none", mem_req_addr));
          e = {mem_req_we, mem_req_addr, mem_req_wdata};
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_we", {31'd0, mem_req_we}, {31'd0, e[64]});
          chk("mem_addr", mem_req_addr, e[63:32]);
          chk("mem_wdata", mem_req_wdata, e[31:0]);
        end
        for (int k = 0; k < rdy_delay; k++) begin
          chk("stall_valid", {31'd0, mem_req_valid}, 32'd1);
          chk("stall_addr", mem_req_addr, e[63:32]);
          chk("stall_quiet", {28'd0, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}, 32'd0);
          @(negedge clk);
        end
        if (rdy_delay > 0) begin
          chk("stall_last_valid", {31'd0, mem_req_valid}, 32'd1);
          chk("stall_last_addr", mem_req_addr, e[63:32]);
        end
        auto_rdy = 1'b1;
        if (same_cyc) begin
          auto_rv = 1'b1;
          auto_rd = mem_rd(e[63:32]);
        end
        @(negedge clk);
        auto_rdy = 1'b0;
        auto_rv  = 1'b0;
        auto_rd  = '0;
        if (!same_cyc) begin
          repeat (resp_lat - 1) @(negedge clk);
          auto_rv = 1'b1;
          auto_rd = mem_rd(e[63:32]);
          @(negedge clk);
          auto_rv = 1'b0;
          auto_rd = '0;
        end
      end
    end
  end

  // Response monitor: every response pulse must match the head of the scoreboard.
  initial begin : monitor
    logic [32:0] r;
    forever begin
      @(negedge clk);
      if (i_resp_valid || d_resp_valid) begin
        resp_cyc = cyc;
        if (i_resp_valid) i_resp_cyc = cyc;
        if (d_resp_valid) d_resp_cyc = cyc;
        if (i_resp_valid && d_resp_valid) fail_now("both_resp", "got i=1 d=1 want one");
        if (exp_resp_q.size() == 0) begin
          fail_now("unexpected_resp",
                   $sformatf("got i=%0b d=%0b want none", i_resp_valid, d_resp_valid));
        end else begin
          r = exp_resp_q.pop_front();
          chk("resp_side_d", {31'd0, d_resp_valid}, {31'd0, r[32]});
          chk("resp_data", d_resp_valid ? d_resp_data : i_resp_data, r[31:0]);
        end
      end
    end
  end

  // Requester tasks: call at a falling edge; hold the request until granted.
  task automatic req_i(input logic [31:0] a);
    int n = 0;
    bit got = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    while (!got && n < 300) begin
      #1;
      if (i_req_ready) begin
        got = 1'b1;
        i_grant_cyc = cyc;
        chk("single_ready_i", {31'd0, d_req_ready}, 32'd0);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) fail_now("i_grant_timeout", $sformatf("got no grant want grant addr %h", a));
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    bit got = 1'b0;
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    while (!got && n < 300) begin
      #1;
      if (d_req_ready) begin
        got = 1'b1;
        d_grant_cyc = cyc;
        chk("single_ready_d", {31'd0, i_req_ready}, 32'd0);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) fail_now("d_grant_timeout", $sformatf("got no grant want grant addr %h", a));
    @(negedge clk);
    d_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_mem_q.size() != 0 || exp_resp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain_timeout", "got pending expectations want none");
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;
    man_rdy = 1'b0;
    man_rv  = 1'b0;
    man_rd  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_req_we}, 32'd0);
    chk("rst_mem_addr", mem_req_addr, 32'd0);
    chk("rst_mem_wdata", mem_req_wdata, 32'd0);
    chk("rst_resp_valids", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
    chk("rst_i_data", i_resp_data, 32'd0);
    chk("rst_d_data", d_resp_data, 32'd0);
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    chk("rst_no_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
    @(negedge clk);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1: I-only read, L=2
    exp_mem(1'b0, 32'h100, 32'h0);
    exp_resp(1'b0, 32'hDEAD_BEEF);
    req_i(32'h100);
    chk("t1_mreq_t1", {31'd0, mem_req_valid}, 32'd1);
    @(negedge clk);
    chk("t1_mreq_t2", {31'd0, mem_req_valid}, 32'd0);
    wait_drain();
    chk("t1_latency", 32'(i_resp_cyc - i_grant_cyc), 32'd4);

    // 2: D store beats I; I granted in the cycle D's ack is high
    exp_mem(1'b1, 32'h200, 32'h55);
    exp_mem(1'b0, 32'h104, 32'h0);
    exp_resp(1'b1, 32'h0);
    exp_resp(1'b0, 32'hC0DE_0104);
    fork
      req_d(1'b1, 32'h200, 32'h55);
      req_i(32'h104);
    join
    wait_drain();
    chk("t2_i_next_idle", 32'(i_grant_cyc), 32'(d_resp_cyc));

    // 3: starvation guard, four D wins then I
    exp_mem(1'b0, 32'h400, 32'h0);
    exp_mem(1'b0, 32'h404, 32'h0);
    exp_mem(1'b0, 32'h408, 32'h0);
    exp_mem(1'b0, 32'h40C, 32'h0);
    exp_mem(1'b0, 32'h500, 32'h0);
    exp_mem(1'b0, 32'h410, 32'h0);
    exp_resp(1'b1, 32'hC0DE_0400);
    exp_resp(1'b1, 32'hC0DE_0404);
    exp_resp(1'b1, 32'hC0DE_0408);
    exp_resp(1'b1, 32'hC0DE_040C);
    exp_resp(1'b0, 32'hC0DE_0500);
    exp_resp(1'b1, 32'hC0DE_0410);
    fork
      begin
        for (int j = 0; j < 5; j++) req_d(1'b0, 32'h400 + 32'(j) * 32'd4, 32'h0);
      end
      req_i(32'h500);
    join
    wait_drain();
    chk("t3_i_before_5th_d", {31'd0, i_grant_cyc < d_grant_cyc}, 32'd1);

    // 4: memory stalls 5 cycles; counter cleared so D wins over a waiting I again
    rdy_delay = 5;
    exp_mem(1'b0, 32'h600, 32'h0);
    exp_mem(1'b0, 32'h700, 32'h0);
    exp_resp(1'b1, 32'hC0DE_0600);
    exp_resp(1'b0, 32'hC0DE_0700);
    fork
      req_d(1'b0, 32'h600, 32'h0);
      req_i(32'h700);
    join
    wait_drain();
    rdy_delay = 0;

    // 5: ready and response in the same ISSUE cycle skip WAIT_RESP
    same_cyc = 1'b1;
    exp_mem(1'b0, 32'h800, 32'h0);
    exp_mem(1'b0, 32'h900, 32'h0);
    exp_resp(1'b0, 32'hC0DE_0800);
    exp_resp(1'b1, 32'hC0DE_0900);
    fork
      req_i(32'h800);
      begin
        @(negedge clk);
        req_d(1'b0, 32'h900, 32'h0);
      end
    join
    wait_drain();
    chk("t5_latency", 32'(i_resp_cyc - i_grant_cyc), 32'd2);
    chk("t5_regrant", 32'(d_grant_cyc - i_grant_cyc), 32'd2);
    same_cyc = 1'b0;

    // 6: reset during WAIT_RESP, late response ignored
    auto_mem = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'hA00;
    #1;
    chk("t6_grant", {31'd0, i_req_ready}, 32'd1);
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("t6_issue_addr", mem_req_addr, 32'hA00);
    man_rdy = 1'b1;
    @(negedge clk);
    man_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("t6_rst_mem_addr", mem_req_addr, 32'd0);
    chk("t6_rst_i_data", i_resp_data, 32'd0);
    chk("t6_rst_d_data", d_resp_data, 32'd0);
    man_rv = 1'b1;
    man_rd = 32'h1234_5678;
    @(negedge clk);
    man_rv = 1'b0;
    man_rd = '0;
    chk("t6_no_late_resp", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
    chk("t6_still_idle", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    auto_mem = 1'b1;
    exp_mem(1'b0, 32'hB00, 32'h0);
    exp_resp(1'b0, 32'hC0DE_0B00);
    req_i(32'hB00);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
